tl_id_responder: RTL and testbench
==================================

TL_ID_RESPONDER -- requirements
Module: tl_id_responder

Interface
REQ-001 SHALL have parameter ID_W, default 4: width of source ID on both channels.
REQ-002 SHALL have parameter DEPTH, default 4, power of two >= 2: outstanding-request capacity.
REQ-003 SHALL have parameter LATENCY, default 2, range 1..7: minimum cycles from request accept to response valid.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-006 a_valid  input  1  request valid.
REQ-007 a_ready  output  1  request ready.
REQ-008 a_source  input  ID_W  request source ID.
REQ-009 a_opcode  input  1  0 = Get, 1 = PutFull.
REQ-010 d_valid  output  1  response valid.
REQ-011 d_ready  input  1  response ready.
REQ-012 d_source  output  ID_W  response source ID; equals the ID of the request being answered.
REQ-013 d_opcode  output  1  0 = AccessAckData (for Get), 1 = AccessAck (for PutFull).
REQ-014 inflight  output  $clog2(DEPTH)+1  count of accepted, not yet responded requests.

Function
REQ-015 SHALL accept a request on a cycle where a_valid and a_ready are both 1 ("a-fire").
REQ-016 SHALL drive a_ready = 1 exactly when inflight < DEPTH; a_ready SHALL NOT depend combinationally on a_valid.
REQ-017 SHALL store each accepted {a_source, a_opcode} in a FIFO entry with an age counter set to 0.
REQ-018 SHALL increment each occupied entry's age by 1 per cycle, saturating at LATENCY.
REQ-019 SHALL drive d_valid = 1 exactly when the FIFO is non-empty and the head entry's age equals LATENCY; first d_valid therefore occurs LATENCY cycles after a-fire.
REQ-020 SHALL drive d_source and d_opcode from the head entry; both stable while d_valid=1 and d_ready=0.
REQ-021 SHALL retire the head on d-fire (d_valid and d_ready); responses SHALL be issued in acceptance order.
REQ-022 Simultaneous a-fire and d-fire SHALL leave inflight unchanged and be legal when full: a_ready stays as computed before the retire, so no same-cycle bypass of full.
REQ-023 SHALL compute inflight as registered count: +1 on a-fire only, -1 on d-fire only, unchanged on both or neither.
REQ-024 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL derive from inflight, never from pointer equality alone.
REQ-025 SHALL never raise d_valid when inflight = 0, and never accept when inflight = DEPTH.

Reset
REQ-026 On reset_n = 0 at a rising edge: inflight = 0, pointers = 0, all ages = 0, d_valid = 0, a_ready = 1 on the following cycle.
REQ-027 Reset mid-operation SHALL discard all outstanding requests with no response issued; d_source/d_opcode reset to 0.
REQ-028 a_valid during reset SHALL NOT be accepted.

Structure
REQ-029 Opcode encodings (GET, PUTFULL, ACCESS_ACK, ACCESS_ACK_DATA) SHALL live in shared package tl_resp_pkg together with the FIFO entry struct type.
REQ-030 Storage plus age counters SHALL be one sub-module, tl_aged_fifo; tl_id_responder adds handshake and count logic.

Verification
REQ-031 Single Get, ID=5, d_ready held 1 -> d_valid rises exactly 2 cycles after a-fire, d_source=5, d_opcode=0, inflight back to 0 next cycle.
REQ-032 Back-to-back PutFull IDs 1,2,3,4, d_ready=0 -> a_ready drops after 4th accept, inflight=4; 5th a_valid not accepted; d_source=1 held stable.
REQ-033 Full FIFO, a_valid=1 and d_ready=1 same cycle -> exactly one retire, no accept that cycle, inflight=3, then accept next cycle.
REQ-034 Ten accepts with IDs 0..9 mod 16 and random d_ready -> responses in identical order, pointers wrap twice, no ID mismatch.
REQ-035 Two requests outstanding, reset_n=0 one cycle -> d_valid=0, inflight=0, no stale response emitted afterward.
REQ-036 Monitor bound alongside SHALL assert d_source equals expected-queue head on every d-fire and never fire over 1000 random cycles.

Source files
------------

// File: rtl/tl_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_resp_pkg
// Description : Shared opcode encodings, FIFO entry metadata type and the
//               request-to-response opcode mapping for the ID responder.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_resp_pkg;

    // Width of the per-entry age counter; large enough for LATENCY up to 7.
    localparam int AGE_W = 3;

    typedef enum logic {
        GET     = 1'b0,
        PUTFULL = 1'b1
    } a_opcode_e;

    typedef enum logic {
        ACCESS_ACK_DATA = 1'b0,
        ACCESS_ACK      = 1'b1
    } d_opcode_e;

    // Per-entry bookkeeping held next to the stored source ID.
    typedef struct packed {
        a_opcode_e        opcode;
        logic [AGE_W-1:0] age;
    } entry_meta_t;

    // A Get is answered with data; a PutFull gets a plain acknowledge.
    function automatic d_opcode_e resp_opcode(input a_opcode_e op);
        return (op == PUTFULL) ? ACCESS_ACK : ACCESS_ACK_DATA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_aged_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tl_aged_fifo
// Description : DEPTH-entry FIFO of {source, opcode}; each occupied entry
//               carries an age counter that saturates at LATENCY so the
//               head can be released only once it has waited long enough.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_aged_fifo
    import tl_resp_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wr_en_i,
    input  logic [ID_W-1:0] wr_source_i,
    input  logic            wr_opcode_i,
    input  logic            rd_en_i,
    output logic [ID_W-1:0] head_source_o,
    output logic            head_opcode_o,
    output logic            head_ripe_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    logic [ID_W-1:0] src_arr  [DEPTH];
    entry_meta_t     meta_arr [DEPTH];
    logic [DEPTH-1:0] occ_arr;

    // Pointer advance; natural PTR_W overflow gives the modulo-DEPTH wrap.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en_i) wptr_d = wptr_q + 1'b1;
        if (rd_en_i) rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [ID_W-1:0] src_q;
        entry_meta_t     meta_q;
        logic            occ_q;
        logic            hit_wr;
        logic            hit_rd;

        assign hit_wr = wr_en_i && (wptr_q == PTR_W'(i));
        assign hit_rd = rd_en_i && (rptr_q == PTR_W'(i));

        // Load on write, free on retire, otherwise age while occupied.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                src_q  <= '0;
                meta_q <= '{opcode: GET, age: '0};
                occ_q  <= 1'b0;
            end else if (hit_wr) begin
                src_q  <= wr_source_i;
                meta_q <= '{opcode: a_opcode_e'(wr_opcode_i), age: '0};
                occ_q  <= 1'b1;
            end else if (hit_rd) begin
                occ_q  <= 1'b0;
            end else if (occ_q && (meta_q.age != AGE_W'(LATENCY))) begin
                meta_q.age <= meta_q.age + 1'b1;
            end
        end

        assign src_arr[i]  = src_q;
        assign meta_arr[i] = meta_q;
        assign occ_arr[i]  = occ_q;
    end

    assign head_source_o = src_arr[rptr_q];
    assign head_opcode_o = meta_arr[rptr_q].opcode;
    assign head_ripe_o   = occ_arr[rptr_q] &&
                           (meta_arr[rptr_q].age == AGE_W'(LATENCY));

endmodule
`default_nettype wire

// File: rtl/tl_id_responder.sv
`default_nettype none
// ============================================================================
// Module      : tl_id_responder
// Description : Answers each accepted request with a response carrying the
//               same source ID, in acceptance order, no earlier than LATENCY
//               cycles after acceptance. Tracks the outstanding count.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_id_responder
    import tl_resp_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ID_W-1:0]          a_source,
    input  logic                     a_opcode,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [ID_W-1:0]          d_source,
    output logic                     d_opcode,
    output logic [$clog2(DEPTH):0]   inflight
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             a_fire;
    logic             d_fire;
    logic             head_ripe;
    logic             head_opcode;

    // Ready comes from the registered count only, so a retire in the same
    // cycle never opens a slot for a full FIFO.
    assign a_ready = (inflight_q < CNT_W'(DEPTH));
    assign d_valid = (inflight_q != '0) && head_ripe;
    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;

    tl_aged_fifo #(
        .ID_W    (ID_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_en_i       (a_fire),
        .wr_source_i   (a_source),
        .wr_opcode_i   (a_opcode),
        .rd_en_i       (d_fire),
        .head_source_o (d_source),
        .head_opcode_o (head_opcode),
        .head_ripe_o   (head_ripe)
    );

    assign d_opcode = resp_opcode(a_opcode_e'(head_opcode));
    assign inflight = inflight_q;

    // Outstanding count: up on accept only, down on retire only.
    always_comb begin
        inflight_d = inflight_q;
        case ({a_fire, d_fire})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Outstanding-count register.
    always_ff @(posedge clock) begin
        if (!reset_n) inflight_q <= '0;
        else          inflight_q <= inflight_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_id_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_id_responder
// Description : Self-checking bench for tl_id_responder. A queue of accepted
//               requests with their acceptance cycle predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_id_responder;

    localparam int ID_W    = 4;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            a_valid;
    logic            a_ready;
    logic [ID_W-1:0] a_source;
    logic            a_opcode;
    logic            d_valid;
    logic            d_ready;
    logic [ID_W-1:0] d_source;
    logic            d_opcode;
    logic [$clog2(DEPTH):0] inflight;

    always #5 clock = ~clock;

    tl_id_responder #(
        .ID_W    (ID_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_source (a_source),
        .a_opcode (a_opcode),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_source (d_source),
        .d_opcode (d_opcode),
        .inflight (inflight)
    );

    typedef struct {
        logic [ID_W-1:0] src;
        logic            op;
        int              acc;
    } req_t;

    req_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        return q.size() < DEPTH;
    endfunction

    // Head may answer once LATENCY full cycles have passed since its accept.
    function automatic logic model_dvalid();
        if (q.size() == 0) return 1'b0;
        return (cyc - q[0].acc - 1) >= LATENCY;
    endfunction

    task automatic check_outputs();
        check("a_ready",  32'(a_ready),  32'(model_ready()));
        check("d_valid",  32'(d_valid),  32'(model_dvalid()));
        check("inflight", 32'(inflight), 32'(q.size()));
        if (model_dvalid()) begin
            check("d_source", 32'(d_source), 32'(q[0].src));
            check("d_opcode", 32'(d_opcode), 32'(q[0].op));
        end
    endtask

    // One clock: check at the negedge, drive, then advance the model.
    task automatic step(input logic rn, input logic av,
                        input logic [ID_W-1:0] src, input logic op,
                        input logic dr);
        logic ar, dv;
        check_outputs();
        reset_n  = rn;
        a_valid  = av;
        a_source = src;
        a_opcode = op;
        d_ready  = dr;
        ar = model_ready();
        dv = model_dvalid();
        if (rn && dv && dr)
            check("mon_dfire_src", 32'(d_source), 32'(q[0].src));
        @(posedge clock);
        if (!rn) begin
            q.delete();
        end else begin
            if (dv && dr) void'(q.pop_front());
            if (av && ar) q.push_back('{src: src, op: op, acc: cyc});
        end
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        reset_n  = 1'b0;
        a_valid  = 1'b0;
        a_source = '0;
        a_opcode = 1'b0;
        d_ready  = 1'b0;
        @(negedge clock);

        // Reset, with a request presented that must be ignored.
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_a_ready",  32'(a_ready),  32'd1);
        check("rst_d_valid",  32'(d_valid),  32'd0);
        check("rst_d_source", 32'(d_source), 32'd0);
        check("rst_d_opcode", 32'(d_opcode), 32'd0);

        // Single Get, ID 5, d_ready held high.
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
        check("get5_dv_0", 32'(d_valid), 32'd0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        check("get5_dv_1", 32'(d_valid), 32'd0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        check("get5_dv_2",  32'(d_valid),  32'd1);
        check("get5_src",   32'(d_source), 32'd5);
        check("get5_op",    32'(d_opcode), 32'd0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        check("get5_infl",  32'(inflight), 32'd0);

        // Four back-to-back PutFulls with d_ready low fill the FIFO.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0);
        check("full_a_ready", 32'(a_ready),  32'd0);
        check("full_infl",    32'(inflight), 32'd4);
        step(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        check("full_5th_infl", 32'(inflight), 32'd4);
        check("full_src_held", 32'(d_source), 32'd1);
        check("full_put_op",   32'(d_opcode), 32'd1);

        // Full with request and retire together: retire only.
        step(1'b1, 1'b1, 4'd6, 1'b0, 1'b1);
        check("fullrt_infl",  32'(inflight), 32'd3);
        check("fullrt_ready", 32'(a_ready),  32'd1);
        step(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
        check("fullrt_acc",   32'(inflight), 32'd4);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        check("drain_infl", 32'(inflight), 32'd0);

        // Ten accepts, IDs 0..9, random d_ready: ordering and pointer wrap.
        for (int i = 0; i < 10; i++) begin
            int guard = 0;
            while (!model_ready() && guard < 50) begin
                step(1'b1, 1'b0, 4'd0, 1'b0, 1'($urandom_range(0, 1)));
                guard++;
            end
            check("ten_guard", 32'(guard < 50), 32'd1);
            step(1'b1, 1'b1, 4'(i), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b0, 4'd0, 1'b0, 1'($urandom_range(0, 1)));
        check("ten_drained", 32'(inflight), 32'd0);

        // Reset with two requests outstanding: no stale response.
        step(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        check("midrst_dv",   32'(d_valid),  32'd0);
        check("midrst_infl", 32'(inflight), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
            check("midrst_stale", 32'(d_valid), 32'd0);
        end

        // Random traffic with rare resets.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 249) != 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
